// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch with a credit-limited prefetch queue and redirect flush
module instr_fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            if_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic            running_q, inflight_q;
  logic [XLEN-1:0] fetch_pc_q, inflight_pc_q;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   occ_q;
  logic            pop, push, issue;

  assign if_valid_o = (occ_q != '0) && !redirect_valid_i;
  assign pop        = if_valid_o && if_ready_i;
  assign push       = inflight_q && !redirect_valid_i;
  // queued plus in-flight entries may never exceed the queue, so a response always has a slot
  assign issue      = running_q && !redirect_valid_i &&
                      (int'(occ_q) + int'(inflight_q) - int'(pop) < DEPTH);

  assign imem_req_valid_o = issue;
  assign imem_addr_o      = fetch_pc_q;
  assign if_instr_o       = instr_q[rd_q];
  assign if_pc_o          = pc_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running_q     <= 1'b0;
      inflight_q    <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      occ_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      running_q  <= 1'b1;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
      if (redirect_valid_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        occ_q <= '0;
        if (running_q) fetch_pc_q <= redirect_pc_i & ~XLEN'(3);
      end else begin
        if (issue) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (push) begin
          instr_q[wr_q] <= imem_rdata_i;
          pc_q[wr_q]    <= inflight_pc_q;
          wr_q          <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        occ_q <= occ_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a stream-level fetch model checked every cycle
module tb_instr_fetch_unit;
  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_ready = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        req, if_valid;
  logic [31:0] addr, rdata, if_instr, if_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  int          cyc = -100;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
    .if_valid_o(if_valid), .if_instr_o(if_instr), .if_pc_o(if_pc), .if_ready_i(if_ready)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .if_valid_o(w_valid), .if_instr_o(w_instr), .if_pc_o(w_pc), .if_ready_i(1'b1)
  );

  always @(posedge clk) begin
    rdata   <= addr ^ TAG;
    w_rdata <= w_addr ^ TAG;
    cyc     <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic neg(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pos(input int n);
    do begin @(posedge clk); #1; end while (cyc < n);
  endtask

  // Stream model: requests and deliveries each walk word addresses from the last restart point
  logic [31:0] exp_pc, next_req;
  int          outst;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc   = 32'h0;
      next_req = 32'h0;
      outst    = 0;
    end else if (redir) begin
      chk("redir_if_valid", if_valid, 0);
      chk("redir_req", req, 0);
      exp_pc   = redir_pc & ~32'h3;
      next_req = exp_pc;
      outst    = 0;
    end else begin
      if (req) begin
        chk("req_addr", addr, next_req);
        next_req = next_req + 4;
        outst++;
      end
      if (if_valid && if_ready) begin
        chk("deliver_pc", if_pc, exp_pc);
        chk("deliver_instr", if_instr, exp_pc ^ TAG);
        exp_pc = exp_pc + 4;
        outst--;
      end
      chk("outstanding_le_depth", 32'(outst <= 2), 1);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    cyc = -1;
    rst_n = 1'b1;
    neg(0);
    chk("c0_req", req, 1);
    chk("c0_addr", addr, 32'h0);
    chk("c0_if_valid", if_valid, 0);
    neg(1);
    chk("c1_if_valid", if_valid, 0);
    chk("c1_addr", addr, 32'h4);
    neg(2);
    chk("c2_if_valid", if_valid, 1);
    chk("c2_pc", if_pc, 32'h0);
    chk("c2_instr", if_instr, 32'hA5A5_0000);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    neg(3);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    neg(4);
    chk("wrap_pc2", w_pc, 32'h0);
    chk("wrap_instr2", w_instr, 32'hA5A5_0000);
    neg(5);
    chk("c5_if_valid", if_valid, 1);
    chk("c5_pc", if_pc, 32'hC);
    pos(6);
    if_ready = 1'b0;
    neg(8);
    chk("stall_req", req, 0);
    chk("stall_if_valid", if_valid, 1);
    chk("stall_pc", if_pc, 32'h10);
    pos(11);
    if_ready = 1'b1;
    neg(11);
    chk("resume_pc0", if_pc, 32'h10);
    neg(12);
    chk("resume_pc1", if_pc, 32'h14);
    neg(13);
    chk("resume_pc2", if_pc, 32'h18);
    chk("resume_req", req, 1);
    pos(15);
    redir = 1'b1;
    redir_pc = 32'h103;
    neg(15);
    chk("redir1_if_valid", if_valid, 0);
    pos(16);
    redir = 1'b0;
    neg(16);
    chk("redir1_req", req, 1);
    chk("redir1_addr", addr, 32'h100);
    neg(17);
    chk("redir1_gap", if_valid, 0);
    neg(18);
    chk("redir1_valid", if_valid, 1);
    chk("redir1_pc", if_pc, 32'h100);
    chk("redir1_instr", if_instr, 32'hA5A5_0100);
    pos(22);
    if_ready = 1'b0;
    pos(24);
    redir = 1'b1;
    redir_pc = 32'h200;
    if_ready = 1'b1;
    neg(24);
    chk("redir2_if_valid", if_valid, 0);
    pos(25);
    redir = 1'b0;
    neg(27);
    chk("redir2_valid", if_valid, 1);
    chk("redir2_pc", if_pc, 32'h200);
    pos(30);
    if_ready = 1'b0;
    neg(32);
    chk("full_req", req, 0);
    chk("full_if_valid", if_valid, 1);
    pos(33);
    rst_n = 1'b0;
    #1;
    chk("arst_req", req, 0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_if_valid", if_valid, 0);
    chk("arst_instr", if_instr, 0);
    chk("arst_pc", if_pc, 0);
    repeat (2) @(negedge clk);
    if_ready = 1'b1;
    cyc = -1;
    rst_n = 1'b1;
    neg(0);
    chk("rel_req", req, 1);
    chk("rel_addr", addr, 32'h0);
    neg(2);
    chk("rel_if_valid", if_valid, 1);
    chk("rel_pc", if_pc, 32'h0);
    neg(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
